// File: rtl/de_delay_ctrl_if.sv
// Sync, host-configuration and result signals of the DE line-delay controller.
// The irq member exists only when DE_DELAY_CTRL_IRQ_EN is defined.
interface de_delay_ctrl_if #(
  parameter int unsigned ROW_W = 11,
  parameter int unsigned COL_W = 12
);
  logic             vs_in;
  logic             hs_in;
  logic             de_in;
  logic             cfg_enable;
  logic             cfg_wr;
  logic [ROW_W-1:0] cfg_delay_num;
  logic [ROW_W-1:0] row_size_o;
  logic [COL_W-1:0] col_size_o;
  logic [ROW_W-1:0] delay_num_o;
  logic             locked;
  logic             fmt_err;
  logic             cfg_pending;
`ifdef DE_DELAY_CTRL_IRQ_EN
  logic             irq;
`endif

  modport master (
    output vs_in, hs_in, de_in, cfg_enable, cfg_wr, cfg_delay_num,
    input  row_size_o, col_size_o, delay_num_o, locked, fmt_err, cfg_pending
`ifdef DE_DELAY_CTRL_IRQ_EN
    , input irq
`endif
  );

  modport slave (
    input  vs_in, hs_in, de_in, cfg_enable, cfg_wr, cfg_delay_num,
    output row_size_o, col_size_o, delay_num_o, locked, fmt_err, cfg_pending
`ifdef DE_DELAY_CTRL_IRQ_EN
    , output irq
`endif
  );
endinterface

// File: rtl/de_delay_ctrl.sv
// Measures frame geometry from vs/de, qualifies it over LOCK_FRAMES frames and applies the
// host delay at frame boundaries. Define DE_DELAY_CTRL_IRQ_EN to add the irq pulse output.
module de_delay_ctrl #(
  parameter int unsigned ROW_W       = 11,
  parameter int unsigned COL_W       = 12,
  parameter int unsigned MAX_DELAY   = 16,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic            clk,
  input logic            rst_b,
  de_delay_ctrl_if.slave bus
);

  localparam int unsigned      MatchW   = $clog2(LOCK_FRAMES + 1);
  localparam logic [ROW_W-1:0] RowMax   = '1;
  localparam logic [COL_W-1:0] ColMax   = '1;
  localparam logic [ROW_W-1:0] MaxDelay = ROW_W'(MAX_DELAY);
  localparam logic [MatchW-1:0] LockCnt = MatchW'(LOCK_FRAMES);

  typedef enum logic [2:0] {StIdle, StAcquire, StMeasure, StLocked, StError} state_e;

  state_e            state_q, state_d;
  logic              vs_d_q, de_d_q;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [COL_W-1:0]  cols_q, cols_d;
  logic [COL_W-1:0]  cur_w_q, cur_w_d;
  logic              bad_q, bad_d;
  logic [MatchW-1:0] match_q, match_d, match_upd;
  logic [ROW_W-1:0]  prev_rows_q, prev_rows_d;
  logic [COL_W-1:0]  prev_cols_q, prev_cols_d;
  logic [ROW_W-1:0]  shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [ROW_W-1:0]  row_size_q, row_size_d;
  logic [COL_W-1:0]  col_size_q, col_size_d;
  logic [ROW_W-1:0]  delay_q, delay_d;
  logic              locked_q, locked_d;
  logic              fmt_err_q, fmt_err_d;
  logic              apply;
  logic [ROW_W-1:0]  lim, apply_val;

  logic vs_rise, vs_fall, de_v, de_rise, line_end, frm_good;

  assign vs_rise  = bus.vs_in & ~vs_d_q;
  assign vs_fall  = ~bus.vs_in & vs_d_q;
  // de only counts inside the active frame, so a line open at vs_fall is closed there.
  assign de_v     = bus.de_in & bus.vs_in;
  assign de_rise  = de_v & ~de_d_q;
  assign line_end = ~de_v & de_d_q;

  always_comb begin
    rows_d  = rows_q;
    cols_d  = cols_q;
    cur_w_d = cur_w_q;
    bad_d   = bad_q;
    if (vs_rise) begin
      rows_d  = '0;
      cols_d  = '0;
      cur_w_d = '0;
      bad_d   = 1'b0;
    end
    if (de_rise) begin
      if (rows_d == RowMax) bad_d = 1'b1;
      else                  rows_d = rows_d + ROW_W'(1);
      cur_w_d = COL_W'(1);
    end else if (de_v) begin
      if (cur_w_d == ColMax) bad_d = 1'b1;
      else                   cur_w_d = cur_w_d + COL_W'(1);
    end
    if (line_end) begin
      if (rows_q == ROW_W'(1))   cols_d = cur_w_q;
      else if (cur_w_q != cols_q) bad_d = 1'b1;
    end
  end

  assign frm_good = ~bad_d & (rows_d != '0);

  always_comb begin
    if (!frm_good) begin
      match_upd = '0;
    end else if (rows_d == prev_rows_q && cols_d == prev_cols_q) begin
      match_upd = (match_q == LockCnt) ? match_q : match_q + MatchW'(1);
    end else begin
      match_upd = MatchW'(1);
    end
  end

  // Applied delay is clamped to the line count of the frame being locked.
  always_comb begin
    lim = rows_d - ROW_W'(1);
    if (MaxDelay < lim) lim = MaxDelay;
    apply_val = (shadow_q < lim) ? shadow_q : lim;
  end

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    prev_rows_d = prev_rows_q;
    prev_cols_d = prev_cols_q;
    row_size_d  = row_size_q;
    col_size_d  = col_size_q;
    fmt_err_d   = 1'b0;
    apply       = 1'b0;
    unique case (state_q)
      StIdle, StAcquire: begin
        match_d     = '0;
        prev_rows_d = '0;
        prev_cols_d = '0;
        if (state_q == StIdle) begin
          if (bus.cfg_enable) state_d = StAcquire;
        end else if (vs_rise) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (vs_fall) begin
          match_d = match_upd;
          if (!frm_good) begin
            fmt_err_d = 1'b1;
          end else begin
            prev_rows_d = rows_d;
            prev_cols_d = cols_d;
            if (match_upd == LockCnt) begin
              state_d    = StLocked;
              row_size_d = rows_d;
              col_size_d = cols_d;
              apply      = 1'b1;
            end
          end
        end
      end
      StLocked: begin
        if (vs_fall) begin
          match_d = match_upd;
          if (frm_good) begin
            prev_rows_d = rows_d;
            prev_cols_d = cols_d;
          end
          if (!frm_good || rows_d != row_size_q || cols_d != col_size_q) begin
            state_d   = StError;
            fmt_err_d = 1'b1;
          end else begin
            apply = 1'b1;
          end
        end
      end
      StError: begin
        if (vs_rise) begin
          state_d = StMeasure;
          match_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!bus.cfg_enable) begin
      state_d    = StIdle;
      fmt_err_d  = 1'b0;
      apply      = 1'b0;
      row_size_d = row_size_q;
      col_size_d = col_size_q;
    end
  end

  always_comb begin
    locked_d = (state_d == StLocked);
    if (!locked_d)  delay_d = '0;
    else if (apply) delay_d = apply_val;
    else            delay_d = delay_q;
    shadow_d  = bus.cfg_wr ? bus.cfg_delay_num : shadow_q;
    // A write in the apply cycle keeps its value pending for the next boundary.
    pending_d = bus.cfg_wr ? 1'b1 : (apply ? 1'b0 : pending_q);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StIdle;
      vs_d_q      <= 1'b0;
      de_d_q      <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      cur_w_q     <= '0;
      bad_q       <= 1'b0;
      match_q     <= '0;
      prev_rows_q <= '0;
      prev_cols_q <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      row_size_q  <= '0;
      col_size_q  <= '0;
      delay_q     <= '0;
      locked_q    <= 1'b0;
      fmt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_d_q      <= bus.vs_in;
      de_d_q      <= de_v;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      cur_w_q     <= cur_w_d;
      bad_q       <= bad_d;
      match_q     <= match_d;
      prev_rows_q <= prev_rows_d;
      prev_cols_q <= prev_cols_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      row_size_q  <= row_size_d;
      col_size_q  <= col_size_d;
      delay_q     <= delay_d;
      locked_q    <= locked_d;
      fmt_err_q   <= fmt_err_d;
    end
  end

  assign bus.row_size_o  = row_size_q;
  assign bus.col_size_o  = col_size_q;
  assign bus.delay_num_o = delay_q;
  assign bus.locked      = locked_q;
  assign bus.fmt_err     = fmt_err_q;
  assign bus.cfg_pending = pending_q;

`ifdef DE_DELAY_CTRL_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = fmt_err_d | (locked_d != locked_q);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign bus.irq = irq_q;
`endif

endmodule
